imem_fetch_responder: RTL and testbench

//  Parametrised instruction-memory responder for the LC3 fetch path; successor to the fixed 16-bit imem bus.

---
 rtl/imem_fetch_responder.sv | 128 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the LC3 fetch path: credit-gated fetch accept, fixed-latency
// read pipeline into an in-order response FIFO, plus a side-band load port for the backing array.
module imem_fetch_responder #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter int                DEPTH      = 256,
  parameter int                RD_LATENCY = 2,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] OOR_WORD   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] PC,
  output logic              rd_ready,
  output logic [DATA_W-1:0] instr_dout,
  output logic              complete_instr,
  output logic              instr_oor,
  input  logic              instr_ack,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = CW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              pc_oor;
  logic [DATA_W-1:0] rd_word;
  logic              accept;

  logic              vld_p  [RD_LATENCY];
  logic [DATA_W-1:0] data_p [RD_LATENCY];
  logic              oor_p  [RD_LATENCY];

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_oor  [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic              push;
  logic              pop;
  logic              head_vld;
  logic [TW-1:0]     inflight;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PW'(FIFO_DEPTH - 1)) return '0;
    return ptr + 1'b1;
  endfunction

  // Upper load_addr bits are intentionally ignored: writes alias modulo DEPTH.
  if (ADDR_W > AW) begin : g_load_hi
    logic unused_load_hi;
    assign unused_load_hi = ^load_addr[ADDR_W-1:AW];
  end

  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr[AW-1:0]] <= load_data;
  end

  // Accept stage: combinational array read, so a same-cycle load is not yet visible.
  assign pc_oor  = {1'b0, PC} >= (ADDR_W + 1)'(DEPTH);
  assign rd_word = pc_oor ? OOR_WORD : mem[PC[AW-1:0]];
  assign accept  = instrmem_rd && rd_ready;

  // Read pipeline: p0 captures the accepted read, the last stage feeds the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clock) begin
    data_p[0] <= rd_word;
    oor_p[0]  <= pc_oor;
    for (int i = 1; i < RD_LATENCY; i++) begin
      data_p[i] <= data_p[i-1];
      oor_p[i]  <= oor_p[i-1];
    end
  end

  // Response FIFO: written from the last pipeline stage, read at the head.
  assign push = vld_p[RD_LATENCY-1];
  assign pop  = (fifo_count != '0) && instr_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= data_p[RD_LATENCY-1];
      fifo_oor[wr_ptr]  <= oor_p[RD_LATENCY-1];
    end
  end

  // Credit counts in-flight reads too, so the FIFO always has room when they land.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + TW'(vld_p[i]);
  end

  assign rd_ready       = !reset && ((inflight + TW'(fifo_count)) < TW'(FIFO_DEPTH));
  assign head_vld       = !reset && (fifo_count != '0);
  assign complete_instr = head_vld;
  assign instr_dout     = head_vld ? fifo_data[rd_ptr] : '0;
  assign instr_oor      = head_vld && fifo_oor[rd_ptr];

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomised and directed bench for imem_fetch_responder against a queue-based response model.
module tb_imem_fetch_responder;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;
  localparam int L      = 2;
  localparam int FD     = 4;
  localparam logic [15:0] OOR = 16'h0000;

  logic              clock;
  logic              reset;
  logic              instrmem_rd;
  logic [ADDR_W-1:0] PC;
  logic              rd_ready;
  logic [DATA_W-1:0] instr_dout;
  logic              complete_instr;
  logic              instr_oor;
  logic              instr_ack;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  imem_fetch_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RD_LATENCY(L), .FIFO_DEPTH(FD), .OOR_WORD(OOR)
  ) dut (
    .clock(clock), .reset(reset), .instrmem_rd(instrmem_rd), .PC(PC),
    .rd_ready(rd_ready), .instr_dout(instr_dout), .complete_instr(complete_instr),
    .instr_oor(instr_oor), .instr_ack(instr_ack), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] data;
    bit          oor;
    int          due;
  } resp_t;

  // Model: memory image, responses still travelling, responses visible to the consumer.
  logic [15:0] mmem [DEPTH];
  resp_t       pend [$];
  resp_t       q    [$];
  bit          cur_rst;
  bit          fresh;
  int          cyc;

  int n_vec;
  int n_bad;

  logic        s_rdy, s_cmp, s_oor;
  logic [15:0] s_dout;
  logic [15:0] obs_d [$];
  bit          obs_o [$];
  int          obs_c [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_o.delete();
    obs_c.delete();
  endtask

  task automatic step(input bit rd, input logic [15:0] pc, input bit ack, input bit ld,
                      input logic [15:0] la, input logic [15:0] ldat, input bit rst);
    bit          exp_rdy, exp_cmp, acc, pp, roor;
    logic [15:0] rdat;
    @(negedge clock);
    exp_cmp = !cur_rst && (q.size() > 0);
    exp_rdy = !cur_rst && (pend.size() + q.size() < FD);
    s_rdy  = rd_ready;
    s_cmp  = complete_instr;
    s_dout = instr_dout;
    s_oor  = instr_oor;
    chk("rd_ready", 32'(rd_ready), 32'(exp_rdy));
    chk("complete_instr", 32'(complete_instr), 32'(exp_cmp));
    if (exp_cmp) begin
      chk("instr_dout", 32'(instr_dout), 32'(q[0].data));
      chk("instr_oor", 32'(instr_oor), 32'(q[0].oor));
    end else if (fresh) begin
      chk("dout_after_reset", 32'(instr_dout), 32'h0);
      chk("oor_after_reset", 32'(instr_oor), 32'h0);
    end
    if (s_cmp && ack) begin
      obs_d.push_back(s_dout);
      obs_o.push_back(s_oor);
      obs_c.push_back(cyc);
    end
    instrmem_rd = rd;
    PC          = pc;
    instr_ack   = ack;
    load_en     = ld;
    load_addr   = la;
    load_data   = ldat;
    reset       = rst;
    acc  = rd && (pend.size() + q.size() < FD);
    pp   = (q.size() > 0) && ack;
    roor = (int'(pc) >= DEPTH);
    rdat = roor ? OOR : mmem[int'(pc)];
    @(posedge clock);
    #1;
    cyc++;
    if (rst) begin
      pend.delete();
      q.delete();
      fresh = 1'b1;
    end else begin
      if (pp) void'(q.pop_front());
      while (pend.size() > 0 && pend[0].due == cyc) begin
        q.push_back(pend.pop_front());
        fresh = 1'b0;
      end
      if (acc) pend.push_back('{rdat, roor, cyc + L});
    end
    if (ld) mmem[int'(la) % DEPTH] = ldat;
    cur_rst = rst;
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) step(0, 16'h0, ack, 0, 16'h0, 16'h0, 0);
  endtask

  initial begin
    int          acc_c, nacc, ncmp;
    logic [15:0] v;
    n_vec = 0; n_bad = 0; cyc = 0;
    cur_rst = 1'b1; fresh = 1'b1;
    reset = 1'b1; instrmem_rd = 1'b0; PC = '0; instr_ack = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < DEPTH; i++) begin
      v = (i < 4) ? 16'h1000 + 16'(i) : (i == 5) ? 16'h1234 : 16'($urandom);
      step(0, 0, 0, 1, 16'(i), v, 0);
    end

    // Back-to-back fetch with ack tied high.
    clear_obs();
    acc_c = cyc;
    for (int i = 0; i < 4; i++) step(1, 16'(i), 1, 0, 0, 0, 0);
    idle(6, 1);
    chk("t1_count", 32'(obs_d.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
      chk("t1_data", 32'(obs_d[i]), 32'h1000 + 32'(i));
      chk("t1_cycle", 32'(obs_c[i]), 32'(acc_c + L + 1 + i));
    end

    // Back-pressure: only FIFO_DEPTH requests get credit.
    clear_obs();
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 16'(nacc), 0, 0, 0, 0, 0);
      if (s_rdy) nacc++;
    end
    chk("t2_accepts", 32'(nacc), 32'd4);
    idle(2, 0);
    chk("t2_head_valid", 32'(s_cmp), 32'd1);
    chk("t2_head_data", 32'(s_dout), 32'h1000);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t2_rdy_at_pop", 32'(s_rdy), 32'd0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t2_rdy_after_pop", 32'(s_rdy), 32'd1);
    idle(4, 1);
    chk("t2_count", 32'(obs_d.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_d.size(); i++)
      chk("t2_data", 32'(obs_d[i]), 32'h1000 + 32'(i));

    // Read/write collision on the same address returns the old word.
    clear_obs();
    step(1, 16'd5, 1, 1, 16'd5, 16'hABCD, 0);
    step(1, 16'd5, 1, 0, 0, 0, 0);
    idle(5, 1);
    chk("t3_count", 32'(obs_d.size()), 32'd2);
    if (obs_d.size() >= 2) begin
      chk("t3_old", 32'(obs_d[0]), 32'h1234);
      chk("t3_new", 32'(obs_d[1]), 32'hABCD);
    end

    // Out-of-range PC, then a normal read.
    clear_obs();
    step(1, 16'h0100, 1, 0, 0, 0, 0);
    step(1, 16'h0000, 1, 0, 0, 0, 0);
    idle(5, 1);
    chk("t4_count", 32'(obs_d.size()), 32'd2);
    if (obs_d.size() >= 2) begin
      chk("t4_oor_data", 32'(obs_d[0]), 32'(OOR));
      chk("t4_oor_flag", 32'(obs_o[0]), 32'd1);
      chk("t4_in_data", 32'(obs_d[1]), 32'h1000);
      chk("t4_in_flag", 32'(obs_o[1]), 32'd0);
    end

    // Reset with two responses queued and two in flight.
    for (int i = 0; i < 4; i++) step(1, 16'(i), 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    clear_obs();
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t5_rdy_after_rst", 32'(s_rdy), 32'd1);
    ncmp = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      if (s_cmp) ncmp++;
    end
    chk("t5_no_stale", 32'(ncmp), 32'd0);
    step(1, 16'd0, 1, 0, 0, 0, 0);
    step(1, 16'd1, 1, 0, 0, 0, 0);
    idle(5, 1);
    chk("t5_count", 32'(obs_d.size()), 32'd2);
    if (obs_d.size() >= 2) begin
      chk("t5_mem0", 32'(obs_d[0]), 32'h1000);
      chk("t5_mem1", 32'(obs_d[1]), 32'h1001);
    end

    // Full credit, then simultaneous push and pop at the FIFO.
    clear_obs();
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 16'(nacc % 4), 0, 0, 0, 0, 0);
      if (s_rdy) nacc++;
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 16'(nacc % 4), 1, 0, 0, 0, 0);
      if (s_rdy) nacc++;
    end
    idle(8, 1);
    chk("t6_count", 32'(obs_d.size()), 32'(nacc));
    for (int i = 0; i < obs_d.size(); i++)
      chk("t6_order", 32'(obs_d[i]), 32'h1000 + 32'(i % 4));

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] pc, la;
      bit rd, ack, ld, rst;
      rst = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 9) < 7);
      pc  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      ack = ($urandom_range(0, 9) < 6);
      ld  = ($urandom_range(0, 4) == 0);
      la  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : pc;
      step(rd, pc, ack, ld, la, 16'($urandom), rst);
    end
    idle(8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
